// File: rtl/rotation_scheduler.sv
// Round-robin rotation scheduler for four swerve wheels: holds one pending angle per wheel,
// limits concurrent rotations, supervises each rotation with a timeout and supports global abort.
module rotation_scheduler #(
    parameter int                  MAX_ACTIVE     = 2,
    parameter int                  TIMEOUT_W      = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_wheel,
    input  logic [11:0] cmd_angle,
    input  logic        abort_all,
    input  logic        err_clear,
    input  logic [3:0]  angle_done,
    output logic [47:0] target_angle,
    output logic [3:0]  angle_update,
    output logic [3:0]  abort_angle,
    output logic [3:0]  busy,
    output logic [2:0]  active_cnt,
    output logic [3:0]  timeout_err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_ACTIVE  = 2'd2;

    localparam logic [2:0]           MAX_ACT  = 3'(MAX_ACTIVE);
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_CYCLES - 1'b1;

    logic [1:0]           r_state      [4];
    logic                 r_pend_valid [4];
    logic [11:0]          r_pend_angle [4];
    logic [11:0]          r_target     [4];
    logic [TIMEOUT_W-1:0] r_timer      [4];
    logic                 r_update     [4];
    logic                 r_abort      [4];
    logic                 r_err        [4];
    logic [1:0]           r_last_grant;
    logic [2:0]           r_active_cnt;

    logic [3:0] w_cand;
    logic [3:0] w_grant;
    logic [3:0] w_next_active;
    logic [1:0] w_idx;
    logic [1:0] w_grant_idx;
    logic [2:0] w_next_cnt;
    logic       w_grant_en;

    // Round-robin search starting one past the last granted wheel; first hit wins.
    always_comb begin
        w_grant_en  = !abort_all && (r_active_cnt < MAX_ACT);
        w_grant     = '0;
        w_grant_idx = '0;
        w_idx       = '0;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_last_grant + 2'd1 + 2'(k);
            if (w_grant_en && (w_grant == 4'd0) && w_cand[w_idx]) begin
                w_grant[w_idx] = 1'b1;
                w_grant_idx    = w_idx;
            end
        end
    end

    always_comb begin
        w_next_cnt = '0;
        for (int k = 0; k < 4; k++) begin
            w_next_cnt = w_next_cnt + 3'(w_next_active[k]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= 2'd3;
            r_active_cnt <= '0;
        end else begin
            if (w_grant != 4'd0) begin
                r_last_grant <= w_grant_idx;
            end
            r_active_cnt <= w_next_cnt;
        end
    end

    assign active_cnt = r_active_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wheel
            logic w_cmd_hit;
            logic w_active;
            logic w_done;
            logic w_tmo;
            logic w_pend_after;

            assign w_cmd_hit = cmd_valid && !abort_all && (cmd_wheel == 2'(gi));
            assign w_active  = (r_state[gi] == ST_ACTIVE);
            // A nonzero timer means at least one edge has passed since the update pulse,
            // so a done level left over from the previous rotation is ignored.
            assign w_done    = w_active && angle_done[gi] && (r_timer[gi] != '0);
            assign w_tmo     = w_active && !w_done && !abort_all && (r_timer[gi] == TMO_LAST);
            assign w_pend_after      = w_cmd_hit || (r_pend_valid[gi] && !w_grant[gi]);
            assign w_cand[gi]        = r_pend_valid[gi] && !w_active;
            assign w_next_active[gi] = !abort_all && (w_grant[gi] || (w_active && !w_done && !w_tmo));

            assign target_angle[12*gi +: 12] = r_target[gi];
            assign angle_update[gi]          = r_update[gi];
            assign abort_angle[gi]           = r_abort[gi];
            assign timeout_err[gi]           = r_err[gi];
            assign busy[gi]                  = (r_state[gi] != ST_IDLE);

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_state[gi]      <= ST_IDLE;
                    r_pend_valid[gi] <= 1'b0;
                    r_pend_angle[gi] <= '0;
                    r_target[gi]     <= '0;
                    r_timer[gi]      <= '0;
                    r_update[gi]     <= 1'b0;
                    r_abort[gi]      <= 1'b0;
                    r_err[gi]        <= 1'b0;
                end else begin
                    r_update[gi]     <= w_grant[gi];
                    r_abort[gi]      <= abort_all ? w_active : w_tmo;
                    r_pend_valid[gi] <= !abort_all && w_pend_after;
                    if (w_cmd_hit) begin
                        r_pend_angle[gi] <= cmd_angle;
                    end
                    if (w_grant[gi]) begin
                        r_target[gi] <= r_pend_angle[gi];
                    end
                    if (w_tmo) begin
                        r_err[gi] <= 1'b1;
                    end else if (err_clear) begin
                        r_err[gi] <= 1'b0;
                    end
                    if (w_next_active[gi] && !w_grant[gi]) begin
                        r_timer[gi] <= (r_timer[gi] == TIMEOUT_CYCLES) ? r_timer[gi] : r_timer[gi] + 1'b1;
                    end else begin
                        r_timer[gi] <= '0;
                    end
                    if (abort_all) begin
                        r_state[gi] <= ST_IDLE;
                    end else if (w_grant[gi]) begin
                        r_state[gi] <= ST_ACTIVE;
                    end else if (w_done || w_tmo) begin
                        r_state[gi] <= w_pend_after ? ST_PENDING : ST_IDLE;
                    end else if ((r_state[gi] == ST_IDLE) && w_cmd_hit) begin
                        r_state[gi] <= ST_PENDING;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_rotation_scheduler.sv
// Directed bench for rotation_scheduler: grant latency, concurrency limit, round-robin,
// overwrite, timeout, abort_all, stale-done blanking and asynchronous reset.
module tb_rotation_scheduler;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_wheel = '0;
    logic [11:0] cmd_angle = '0;
    logic        abort_all = 1'b0;
    logic        err_clear = 1'b0;
    logic [3:0]  angle_done = '0;
    logic [47:0] target_angle;
    logic [3:0]  angle_update;
    logic [3:0]  abort_angle;
    logic [3:0]  busy;
    logic [2:0]  active_cnt;
    logic [3:0]  timeout_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    rotation_scheduler #(
        .MAX_ACTIVE    (2),
        .TIMEOUT_W     (24),
        .TIMEOUT_CYCLES(24'd100)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_wheel   (cmd_wheel),
        .cmd_angle   (cmd_angle),
        .abort_all   (abort_all),
        .err_clear   (err_clear),
        .angle_done  (angle_done),
        .target_angle(target_angle),
        .angle_update(angle_update),
        .abort_angle (abort_angle),
        .busy        (busy),
        .active_cnt  (active_cnt),
        .timeout_err (timeout_err)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            n_pass++;
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic send_cmd(input logic [1:0] w, input logic [11:0] a);
        cmd_valid = 1'b1;
        cmd_wheel = w;
        cmd_angle = a;
        tick();
        cmd_valid = 1'b0;
    endtask

    function automatic logic [47:0] wheel_tgt(input int w);
        return 48'(target_angle[12*w +: 12]);
    endfunction

    initial begin
        // Reset state
        tick();
        tick();
        check_val("rst_target", target_angle, 48'h0);
        check_val("rst_busy", 48'(busy), 48'h0);
        check_val("rst_cnt", 48'(active_cnt), 48'h0);
        check_val("rst_upd", 48'(angle_update), 48'h0);
        reset_n = 1'b1;
        tick();

        // Basic grant: wheel 2, angle 0x1F4
        send_cmd(2'd2, 12'h1F4);
        check_val("basic_pend_busy", 48'(busy), 48'h4);
        check_val("basic_pend_upd", 48'(angle_update), 48'h0);
        tick();
        check_val("basic_upd", 48'(angle_update), 48'h4);
        check_val("basic_tgt", wheel_tgt(2), 48'h1F4);
        check_val("basic_cnt1", 48'(active_cnt), 48'h1);
        tick();
        check_val("basic_upd_off", 48'(angle_update), 48'h0);
        tick(); tick(); tick();
        angle_done = 4'b0100;
        tick();
        angle_done = 4'b0000;
        check_val("basic_done_busy", 48'(busy), 48'h0);
        check_val("basic_done_cnt", 48'(active_cnt), 48'h0);
        check_val("basic_tgt_hold", wheel_tgt(2), 48'h1F4);

        // Concurrency limit and round-robin (last_grant = 2)
        send_cmd(2'd0, 12'h100);
        send_cmd(2'd1, 12'h101);
        check_val("rr_upd_w0", 48'(angle_update), 48'h1);
        send_cmd(2'd2, 12'h102);
        check_val("rr_upd_w1", 48'(angle_update), 48'h2);
        send_cmd(2'd3, 12'h103);
        check_val("rr_limit_upd", 48'(angle_update), 48'h0);
        check_val("rr_limit_cnt", 48'(active_cnt), 48'h2);
        check_val("rr_limit_busy", 48'(busy), 48'hF);
        angle_done = 4'b0010;
        tick();
        angle_done = 4'b0000;
        check_val("rr_w1_done_busy", 48'(busy), 48'hD);
        check_val("rr_w1_done_cnt", 48'(active_cnt), 48'h1);
        tick();
        check_val("rr_upd_w2", 48'(angle_update), 48'h4);
        check_val("rr_tgt_w2", wheel_tgt(2), 48'h102);
        angle_done = 4'b0001;
        tick();
        angle_done = 4'b0000;
        check_val("rr_w0_done_cnt", 48'(active_cnt), 48'h1);
        tick();
        check_val("rr_upd_w3", 48'(angle_update), 48'h8);
        check_val("rr_tgt_w3", wheel_tgt(3), 48'h103);
        check_val("rr_cnt_w3", 48'(active_cnt), 48'h2);
        tick();
        angle_done = 4'b1100;
        tick();
        angle_done = 4'b0000;
        check_val("rr_drain_busy", 48'(busy), 48'h0);

        // Overwrite while active: latest pending angle wins
        send_cmd(2'd0, 12'h0AA);
        tick();
        check_val("ow_upd_first", 48'(angle_update), 48'h1);
        check_val("ow_tgt_first", wheel_tgt(0), 48'h0AA);
        send_cmd(2'd0, 12'h010);
        send_cmd(2'd0, 12'h020);
        check_val("ow_no_upd", 48'(angle_update), 48'h0);
        check_val("ow_tgt_kept", wheel_tgt(0), 48'h0AA);
        angle_done = 4'b0001;
        tick();
        angle_done = 4'b0000;
        check_val("ow_done_cnt", 48'(active_cnt), 48'h0);
        check_val("ow_done_pending", 48'(busy), 48'h1);
        tick();
        check_val("ow_upd_second", 48'(angle_update), 48'h1);
        check_val("ow_tgt_second", wheel_tgt(0), 48'h020);
        tick();
        check_val("ow_single_pulse", 48'(angle_update), 48'h0);
        angle_done = 4'b0001;
        tick();
        angle_done = 4'b0000;
        check_val("ow_final_busy", 48'(busy), 48'h0);

        // Timeout of wheel 1 after 100 cycles
        send_cmd(2'd1, 12'h055);
        tick();
        check_val("tmo_upd", 48'(angle_update), 48'h2);
        for (int i = 0; i < 99; i++) tick();
        check_val("tmo_early_abort", 48'(abort_angle), 48'h0);
        check_val("tmo_early_busy", 48'(busy), 48'h2);
        tick();
        check_val("tmo_abort", 48'(abort_angle), 48'h2);
        check_val("tmo_err", 48'(timeout_err), 48'h2);
        check_val("tmo_busy", 48'(busy), 48'h0);
        tick();
        check_val("tmo_abort_off", 48'(abort_angle), 48'h0);
        check_val("tmo_err_sticky", 48'(timeout_err), 48'h2);
        check_val("tmo_tgt_hold", wheel_tgt(1), 48'h055);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check_val("tmo_err_clear", 48'(timeout_err), 48'h0);

        // abort_all with wheels 0,3 active, wheel 1 pending, simultaneous command to wheel 2
        send_cmd(2'd3, 12'h333);
        send_cmd(2'd0, 12'h030);
        check_val("ab_upd_w3", 48'(angle_update), 48'h8);
        tick();
        check_val("ab_upd_w0", 48'(angle_update), 48'h1);
        send_cmd(2'd1, 12'h011);
        check_val("ab_pre_busy", 48'(busy), 48'hB);
        abort_all = 1'b1;
        cmd_valid = 1'b1;
        cmd_wheel = 2'd2;
        cmd_angle = 12'h222;
        tick();
        abort_all = 1'b0;
        cmd_valid = 1'b0;
        check_val("ab_abort", 48'(abort_angle), 48'h9);
        check_val("ab_busy", 48'(busy), 48'h0);
        check_val("ab_cnt", 48'(active_cnt), 48'h0);
        tick();
        check_val("ab_abort_off", 48'(abort_angle), 48'h0);
        check_val("ab_no_upd", 48'(angle_update), 48'h0);
        check_val("ab_busy_after", 48'(busy), 48'h0);

        // Stale done level is blanked for the first edge after the update
        angle_done = 4'b0001;
        send_cmd(2'd0, 12'h0CC);
        tick();
        check_val("stale_upd", 48'(angle_update), 48'h1);
        tick();
        check_val("stale_blank_busy", 48'(busy), 48'h1);
        check_val("stale_blank_cnt", 48'(active_cnt), 48'h1);
        tick();
        check_val("stale_done_busy", 48'(busy), 48'h0);
        angle_done = 4'b0000;

        // Asynchronous reset while wheel 0 is active
        send_cmd(2'd0, 12'h0DD);
        tick();
        tick();
        check_val("rst2_pre_cnt", 48'(active_cnt), 48'h1);
        reset_n = 1'b0;
        #1;
        check_val("rst2_target", target_angle, 48'h0);
        check_val("rst2_busy", 48'(busy), 48'h0);
        check_val("rst2_cnt", 48'(active_cnt), 48'h0);
        check_val("rst2_abort", 48'(abort_angle), 48'h0);
        tick();
        check_val("rst2_abort_held", 48'(abort_angle), 48'h0);
        reset_n = 1'b1;
        tick();
        check_val("rst2_abort_after", 48'(abort_angle), 48'h0);
        check_val("rst2_busy_after", 48'(busy), 48'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rotation_scheduler.md
# rotation_scheduler

Sequences target-angle commands to the four wheel rotation controllers (one `pwm_ctrl` per swerve wheel) and limits how many wheels rotate at once to stay within the power budget. It accepts angle commands from the FPGA subsystem register interface and holds one pending command per wheel. It grants rotations round-robin, supervises each rotation with a timeout, and aborts stalled or cancelled rotations.

## Interface
- `MAX_ACTIVE`, 2: maximum number of wheels rotating at the same time (1..4).
- `TIMEOUT_W`, 24: width of the per-wheel timeout counter.
- `TIMEOUT_CYCLES`, 24'd5_000_000: clocks allowed from the grant until `angle_done`.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clock`  in  1  main clock; all logic is on the rising edge.
- `cmd_valid`  in  1  a command is presented this cycle; it is always accepted.
- `cmd_wheel`  in  2  wheel index 0..3.
- `cmd_angle`  in  12  target angle for that wheel.
- `abort_all`  in  1  cancels every active and pending rotation.
- `err_clear`  in  1  clears every `timeout_err` bit.
- `angle_done`  in  4  per-wheel completion level from each `pwm_ctrl`.
- `target_angle`  out  48  per-wheel target; wheel n occupies [12n+11:12n]; registered.
- `angle_update`  out  4  one-cycle request pulse to each `pwm_ctrl`.
- `abort_angle`  out  4  one-cycle abort pulse to each `pwm_ctrl`.
- `busy`  out  4  wheel n is pending or active.
- `active_cnt`  out  3  number of wheels currently active.
- `timeout_err`  out  4  sticky per-wheel timeout flag.

## Operation
- Each wheel has a state: IDLE, PENDING or ACTIVE. Each wheel also has a pending register (`pend_valid` plus a 12-bit angle).
- **Command:** a command writes the pending register of `cmd_wheel`. If a command is already pending, the new one overwrites it (latest wins). A wheel in IDLE moves to PENDING. A wheel in ACTIVE keeps rotating and its pending command waits.
- **Arbitration:** at most one grant per cycle, and only when `active_cnt < MAX_ACTIVE`.
  - Candidates are wheels with `pend_valid=1` that are not ACTIVE.
  - Search order is round-robin starting at `last_grant+1` (mod 4).
  - `last_grant` resets to 3, so wheel 0 has first priority after reset.
- **Grant to wheel n:**
  - `target_angle[n]` is loaded with the pending angle.
  - `pend_valid[n]` is cleared.
  - `angle_update[n]` pulses high for 1 cycle.
  - The timeout counter is cleared and the wheel moves to ACTIVE.
- **Completion:** an ACTIVE wheel completes when `angle_done[n]=1` is sampled 2 or more cycles after its `angle_update` pulse. The 2-cycle blanking ignores a stale done level from the previous rotation. On completion the wheel goes to PENDING if `pend_valid` is set, otherwise to IDLE.
- **Timeout:** the counter increments every cycle while ACTIVE. When it reaches `TIMEOUT_CYCLES`:
  - `abort_angle[n]` pulses for 1 cycle.
  - `timeout_err[n]` is set.
  - The wheel goes to PENDING or IDLE, following the completion rule.
- **abort_all:**
  - Every ACTIVE wheel pulses `abort_angle` for 1 cycle.
  - All `pend_valid` bits clear and all wheels go to IDLE.
  - No grant is issued that cycle.
- `target_angle` changes only at a grant. It holds its value through completion, abort and timeout.
- `active_cnt` is a registered count of wheels in ACTIVE.

## Timing
- **Reset values:** all outputs are 0 (`target_angle`=0, `angle_update`=0, `abort_angle`=0, `busy`=0, `active_cnt`=0, `timeout_err`=0); all wheels IDLE; `last_grant`=3. Reset asserted mid-rotation returns to this state immediately and issues no abort pulse.
- **Command-to-update latency:** a command sampled at edge E0 reaches PENDING at E0. If a slot is free, `angle_update` is high from E1 to E2, and `target_angle` is valid from E1 onward.
- **Freed slot:** a completion registered at edge Ek frees its slot, which allows a grant at edge Ek+1.
- **Simultaneous events:**
  - Command and grant for the same wheel in the same cycle: the grant takes the old pending angle, and the new command remains pending.
  - `abort_all` and `cmd_valid` in the same cycle: the abort wins and the command is dropped.
  - Completion and timeout in the same cycle: completion wins, and no abort or error is raised.
  - `err_clear` and a new timeout in the same cycle: the set wins.
- **Counter width:** `TIMEOUT_CYCLES` must be less than 2^`TIMEOUT_W`. The counter saturates and never wraps.
- `busy[n]` is 1 whenever wheel n is PENDING or ACTIVE. It is registered and updates in the same edge as the state.

## Test plan
- **Basic grant:** after reset, command wheel 2 to angle 0x1F4 → 2 edges later `angle_update`=4'b0100 for 1 cycle and `target_angle[35:24]`=0x1F4. Raise `angle_done[2]` 5 cycles later → `busy[2]`=0 and `active_cnt`=0.
- **Concurrency limit and round-robin:** with `MAX_ACTIVE`=2, command wheels 0, 1, 2 and 3 on consecutive cycles → wheels 0 and 1 are granted, `active_cnt`=2. Complete wheel 1 → wheel 2 is granted next. Complete wheel 0 → wheel 3 is granted.
- **Overwrite:** while wheel 0 is ACTIVE, command it with 0x010 then 0x020 → after completion the next grant loads 0x020 only, with one `angle_update` pulse.
- **Timeout:** with `TIMEOUT_CYCLES`=100, grant wheel 1 and never assert done → at cycle 100 after the grant `abort_angle[1]` pulses once, `timeout_err[1]`=1 and the wheel goes IDLE. `err_clear` → `timeout_err`=0.
- **abort_all:** with wheels 0 and 3 active and wheel 1 pending, assert `abort_all` together with a command to wheel 2 → `abort_angle`=4'b1001 for 1 cycle, `busy`=0 and no `angle_update` follows.
- **Stale done and reset:** hold `angle_done[0]`=1, then grant wheel 0 → no completion until cycle 2 after the update pulse. Assert `reset_n`=0 while wheel 0 is ACTIVE → all outputs are 0 and no abort pulse is issued.
